// File: rtl/register_file_32x32_if.sv
// Bus bundle for the 32x32 register file: two combinational read ports,
// one write port with write-through bypass, and the comparison-flag capture port.
interface register_file_32x32_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              flags_we;
  logic              lt_in;
  logic              eq_in;
  logic              gt_in;
  logic              lt;
  logic              eq;
  logic              gt;

  // No valid/ready pair here: we and flags_we are single-cycle strobes
  // sampled on every rising clk, and the read ports are always ready.
  modport master (
    output ra1, ra2, we, wa, wd, flags_we, lt_in, eq_in, gt_in,
    input  rd1, rd2, lt, eq, gt
  );

  modport slave (
    input  ra1, ra2, we, wa, wd, flags_we, lt_in, eq_in, gt_in,
    output rd1, rd2, lt, eq, gt
  );
endinterface

// File: rtl/register_file_32x32.sv
// Two-read/one-write register file with zero register, write-through bypass
// and a registered {lt,eq,gt} flag set captured from the ALU.
module register_file_32x32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    register_file_32x32_if.slave  rf
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              lt_q;
    logic              eq_q;
    logic              gt_q;
    logic              wr_en;

    assign wr_en = rf.we && (rf.wa != '0);

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rf.wa] <= rf.wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lt_q <= 1'b0;
            eq_q <= 1'b0;
            gt_q <= 1'b0;
        end else if (rf.flags_we) begin
            lt_q <= rf.lt_in;
            eq_q <= rf.eq_in;
            gt_q <= rf.gt_in;
        end
    end

    // Reads force zero during reset so the bypass path cannot leak wd.
    always_comb begin
        rf.rd1 = '0;
        if (rst_n && (rf.ra1 != '0)) begin
            if (wr_en && (rf.wa == rf.ra1)) begin
                rf.rd1 = rf.wd;
            end else begin
                rf.rd1 = regs[rf.ra1];
            end
        end
    end

    always_comb begin
        rf.rd2 = '0;
        if (rst_n && (rf.ra2 != '0)) begin
            if (wr_en && (rf.wa == rf.ra2)) begin
                rf.rd2 = rf.wd;
            end else begin
                rf.rd2 = regs[rf.ra2];
            end
        end
    end

    assign rf.lt = lt_q;
    assign rf.eq = eq_q;
    assign rf.gt = gt_q;

endmodule

// File: tb/tb_register_file_32x32.sv
// Directed bench for register_file_32x32: reset, write/read, zero register,
// bypass, flag capture and an ALU subtract loop.
module tb_register_file_32x32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    register_file_32x32_if #(.DATA_W(32), .ADDR_W(5)) rf ();

    register_file_32x32 #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        rf.we = 1'b1;
        rf.wa = a;
        rf.wd = d;
        tick();
        rf.we = 1'b0;
    endtask

    logic [31:0] alu_res;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n       = 1'b0;
        rf.ra1      = 5'd5;
        rf.ra2      = 5'd0;
        rf.we       = 1'b1;
        rf.wa       = 5'd5;
        rf.wd       = 32'hDEADBEEF;
        rf.flags_we = 1'b1;
        rf.lt_in    = 1'b1;
        rf.eq_in    = 1'b1;
        rf.gt_in    = 1'b1;

        // Held in reset across the edge at t=5: no write, no bypass, no flags.
        #12;
        check("rst_rd1_bypass_off", rf.rd1, 32'h0);
        check("rst_flags", {29'b0, rf.lt, rf.eq, rf.gt}, 32'h0);

        // Released between edges: bypass live now, first edge writes.
        rst_n = 1'b1;
        #1;
        check("post_rst_bypass", rf.rd1, 32'hDEADBEEF);
        tick();
        rf.we = 1'b0;
        rf.flags_we = 1'b0;
        #1;
        check("first_write_after_rst", rf.rd1, 32'hDEADBEEF);
        check("first_flags_after_rst", {29'b0, rf.lt, rf.eq, rf.gt}, 32'h7);

        // Asynchronous reset pulse between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd1", rf.rd1, 32'h0);
        check("async_rst_flags", {29'b0, rf.lt, rf.eq, rf.gt}, 32'h0);
        rst_n = 1'b1;

        // Reset asserted while a write to reg[9] is pending.
        rf.we  = 1'b1;
        rf.wa  = 5'd9;
        rf.wd  = 32'd55;
        rf.ra2 = 5'd9;
        #1;
        check("midwrite_bypass", rf.rd2, 32'd55);
        rst_n = 1'b0;
        #1;
        check("midwrite_rst_bypass_off", rf.rd2, 32'h0);
        tick();
        rf.we = 1'b0;
        rst_n = 1'b1;
        #1;
        check("midwrite_rst_wins", rf.rd2, 32'h0);

        // Write then read both ports.
        write_reg(5'd3, 32'd23);
        rf.ra1 = 5'd3;
        rf.ra2 = 5'd3;
        #1;
        check("wr_rd1", rf.rd1, 32'd23);
        check("wr_rd2", rf.rd2, 32'd23);

        // we=0 must not change anything.
        rf.we = 1'b0;
        rf.wa = 5'd3;
        rf.wd = 32'd999;
        tick();
        check("we0_hold", rf.rd1, 32'd23);

        // Zero register ignores writes and bypass.
        rf.we  = 1'b1;
        rf.wa  = 5'd0;
        rf.wd  = 32'hFFFFFFFF;
        rf.ra1 = 5'd0;
        #1;
        check("zero_same_cycle", rf.rd1, 32'h0);
        tick();
        rf.we = 1'b0;
        #1;
        check("zero_next_cycle", rf.rd1, 32'h0);

        // Bypass on port 1 while port 2 reads an unrelated register.
        write_reg(5'd6, 32'd66);
        write_reg(5'd7, 32'd4);
        rf.we  = 1'b1;
        rf.wa  = 5'd7;
        rf.wd  = 32'd11;
        rf.ra1 = 5'd7;
        rf.ra2 = 5'd6;
        #1;
        check("bypass_rd1", rf.rd1, 32'd11);
        check("bypass_rd2_unrelated", rf.rd2, 32'd66);
        tick();
        rf.we = 1'b0;
        #1;
        check("bypass_committed", rf.rd1, 32'd11);

        // Flag capture and hold.
        rf.flags_we = 1'b1;
        {rf.lt_in, rf.eq_in, rf.gt_in} = 3'b100;
        tick();
        check("flags_capture", {29'b0, rf.lt, rf.eq, rf.gt}, 32'h4);
        rf.flags_we = 1'b0;
        {rf.lt_in, rf.eq_in, rf.gt_in} = 3'b010;
        tick();
        check("flags_hold", {29'b0, rf.lt, rf.eq, rf.gt}, 32'h4);

        // ALU loop: reg[3] = reg[1] - reg[2] with flags captured together.
        write_reg(5'd1, 32'd4);
        write_reg(5'd2, 32'd5);
        rf.ra1 = 5'd1;
        rf.ra2 = 5'd2;
        #1;
        alu_res = rf.rd1 - rf.rd2;
        rf.we = 1'b1;
        rf.wa = 5'd3;
        rf.wd = alu_res;
        rf.flags_we = 1'b1;
        rf.lt_in = (rf.rd1 < rf.rd2);
        rf.eq_in = (rf.rd1 == rf.rd2);
        rf.gt_in = (rf.rd1 > rf.rd2);
        tick();
        rf.we = 1'b0;
        rf.flags_we = 1'b0;
        rf.ra1 = 5'd3;
        #1;
        check("alu_reg3", rf.rd1, 32'hFFFFFFFF);
        check("alu_flags", {29'b0, rf.lt, rf.eq, rf.gt}, 32'h4);

        // Untouched registers still read zero after all writes.
        rf.ra2 = 5'd31;
        #1;
        check("reg31_untouched", rf.rd2, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
